// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial bit source with a one-word holding register.
// Ports: clk, reset; din/din_valid/din_ready word input; bit_en strobe; outbit/bit_valid/last_bit serial output.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             outbit,
  output logic             bit_valid,
  output logic             last_bit
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             at_last;
  logic [WIDTH-1:0] sreg_shifted;

  // Ready depends only on the holding flag, so a word can only
  // be accepted while no transfer out of hold is possible.
  assign accept  = din_valid && !hold_full_q;
  assign at_last = (cnt_q == LAST);

  // Vacated bit is a don't-care; zero keeps it deterministic.
  assign sreg_shifted = MSB_FIRST ? (sreg_q << 1)
                                  : (sreg_q >> 1);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // Transfer does not wait for bit_en.
        if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_en) begin
          if (!at_last) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + CW'(1);
          end else if (hold_full_q) begin
            // Back-to-back reload: no idle bit between words.
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Never collides with a transfer: both need opposite
    // values of hold_full_q.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs decode registers only; no path from din/din_valid.
  assign din_ready = !hold_full_q;
  assign bit_valid = (state_q == S_SHIFT);
  assign last_bit  = bit_valid && at_last;

  always_comb begin
    outbit = IDLE_BIT;
    if (state_q == S_SHIFT) begin
      outbit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial bit source that sits directly upstream of the team's serial sequence detectors (e.g. the 1011 Mealy detector). It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on `outbit`, qualified by `bit_valid`. A one-word holding register lets consecutive words stream with no idle bit between them. All outputs come from registers, with no combinational path from `din`/`din_valid` to `outbit`.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = transmit `din[WIDTH-1]` first; 0 = transmit `din[0]` first.
- `IDLE_BIT`, 1'b0: value driven on `outbit` while no word is being shifted.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `din`  in  WIDTH  word to serialize; sampled only on an accept edge.
- `din_valid`  in  1  upstream has a word on `din`.
- `din_ready`  out  1  holding register is empty; a word is accepted when `din_valid && din_ready` at a rising edge.
- `bit_en`  in  1  bit strobe; the shifter advances only on edges where `bit_en=1`. Tie to 1 for one bit per clock.
- `outbit`  out  1  current serial bit; feeds the detector's data input.
- `bit_valid`  out  1  `outbit` carries a data bit. The consumer takes one bit per edge where `bit_valid && bit_en`.
- `last_bit`  out  1  `bit_valid` is high and `outbit` is the final bit of the current word.

## Operation
- Storage:
  - Holding register `hold[WIDTH-1:0]` with flag `hold_full`.
  - Shift register `sreg[WIDTH-1:0]`.
  - Bit counter `cnt`, $clog2(WIDTH) bits.
  - Two-state FSM: IDLE, SHIFT.
- `din_ready = !hold_full`, driven from the register only.
- Accept: on an edge with `din_valid && !hold_full`, `hold<=din` and `hold_full<=1`. When `din_valid=0`, `din` is ignored.
- IDLE:
  - If `hold_full`: `sreg<=hold`, `hold_full<=0`, `cnt<=0`, go to SHIFT. This happens regardless of `bit_en`.
  - Otherwise stay in IDLE.
- SHIFT, edge with `bit_en=0`: all of `sreg`, `cnt` and state hold.
- SHIFT, edge with `bit_en=1` and `cnt<WIDTH-1`:
  - Shift `sreg` left if `MSB_FIRST`, right otherwise; the vacated bit is don't-care.
  - `cnt<=cnt+1`.
- SHIFT, edge with `bit_en=1` and `cnt==WIDTH-1` (last bit consumed):
  - If `hold_full`: reload `sreg<=hold`, `hold_full<=0`, `cnt<=0`, stay in SHIFT. No gap between words.
  - Otherwise go to IDLE.
- Outputs:
  - `outbit` = `sreg[WIDTH-1]` if `MSB_FIRST`, else `sreg[0]`, while in SHIFT; `IDLE_BIT` while in IDLE.
  - `bit_valid` = (state==SHIFT).
  - `last_bit` = `bit_valid && cnt==WIDTH-1`.
- Simultaneous accept and transfer cannot occur, because ready is low whenever `hold` is full. A word accepted on the same edge that the last bit is consumed without reload waits in `hold`. It is loaded on the next edge from IDLE, giving exactly one IDLE cycle.
- `cnt` never exceeds WIDTH-1. There is no wrap-around beyond the reload.

## Timing
- Reset values:
  - state IDLE, `hold_full=0`, `cnt=0`, `sreg=0`, `hold=0`.
  - `din_ready=1`, `outbit=IDLE_BIT`, `bit_valid=0`, `last_bit=0`.
- Reset mid-word discards both the shifting word and the held word. Outputs return to reset values after that edge.
- Latency: word accepted at edge E0 with the shifter IDLE → first bit on `outbit` with `bit_valid=1` after E1.
- Each bit is held until an edge with `bit_en=1`. A word therefore occupies ≥ WIDTH cycles.
- `din_ready` falls the cycle after an accept. It rises the cycle after `hold` transfers into `sreg`.
- Sustained throughput: one word per WIDTH enabled cycles, provided upstream refills `hold` within WIDTH-1 cycles of each transfer.

## Test plan
- Reset, then idle for 5 cycles → `outbit=IDLE_BIT`, `bit_valid=0`, `last_bit=0`, `din_ready=1` throughout.
- MSB_FIRST=1, WIDTH=8, `bit_en=1`, single word 8'hB0 → starting one cycle after accept, `outbit` = 1,0,1,1,0,0,0,0 with `bit_valid=1` for 8 cycles, `last_bit` on the 8th, then IDLE.
- Back-to-back words 8'hB0 then 8'hD0, second offered while the first shifts → 16 consecutive `bit_valid` cycles. `din_ready` is low from the accept of 8'hD0 until the cycle after its transfer. The downstream 1011 detector fires on exactly the expected bits.
- Backpressure: hold `din_valid=1` continuously with three words → each word is accepted only when `din_ready=1`, none is lost or duplicated, and the output order matches the input order.
- `bit_en` toggling 1,0,0,1,… during word 8'hA5 → `outbit` holds its value across `bit_en=0` cycles, and the bit sequence is unchanged.
- Reset asserted during bit 3 of a word, with a second word in `hold` → after the reset edge, `bit_valid=0` and `din_ready=1`. Neither word is emitted afterwards. A new word 8'h0F serializes correctly. Repeat with MSB_FIRST=0, where 8'h0F gives 1,1,1,1,0,0,0,0.
